// File: rtl/bcd_limit_counter.sv
// bcd_limit_counter: multi-digit BCD counter with programmable terminal value, up/down, saturate or wrap.
// Define BCD_CNT_LOAD_EN to add the synchronous LOAD/LOAD_VAL preset.
module bcd_limit_counter #(
    parameter int DIGITS = 2,
    parameter int LIMIT  = 30,
    parameter bit WRAP   = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CLR,
    input  logic                en,
    input  logic                HOLD,
    input  logic                DOWN,
`ifdef BCD_CNT_LOAD_EN
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
`endif
    output logic [4*DIGITS-1:0] Q,
    output logic                AT_LIMIT,
    output logic                CA
);
    localparam int W = 4*DIGITS;

    if (LIMIT <= 0 || LIMIT >= 10**DIGITS) begin : g_bad_limit
        $error("bcd_limit_counter: LIMIT %0d out of range for %0d digits", LIMIT, DIGITS);
    end

    function automatic logic [W-1:0] to_bcd(input int v);
        int r;
        r = v;
        to_bcd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            to_bcd[4*k+:4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // Ripple the carry/borrow digit by digit; a digit only moves while all lower digits rolled over.
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dn);
        logic       c;
        logic [3:0] d;
        c = 1'b1;
        bcd_step = v;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k+:4];
            bcd_step[4*k+:4] = !c ? d : dn ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
            c = c && (dn ? d == 4'd0 : d == 4'd9);
        end
    endfunction

    localparam logic [W-1:0] LIM = to_bcd(LIMIT);

    logic         at_zero, at_lim, step, load, ca_n;
    logic [W-1:0] stepped, load_q;

    assign at_zero  = Q == '0;
    assign at_lim   = Q == LIM;
    assign AT_LIMIT = DOWN ? at_zero : at_lim;
    assign step     = en && !HOLD;
    assign stepped  = DOWN ? (at_zero ? (WRAP ? LIM : Q) : bcd_step(Q, 1'b1))
                           : (at_lim ? (WRAP ? {W{1'b0}} : Q) : bcd_step(Q, 1'b0));
    // Only a step that actually lands on the terminal counts, so saturation never re-fires.
    assign ca_n     = DOWN ? (stepped == '0 && !at_zero) : (stepped == LIM && !at_lim);

`ifdef BCD_CNT_LOAD_EN
    function automatic logic bcd_ok(input logic [W-1:0] v);
        bcd_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k+:4] > 4'd9) bcd_ok = 1'b0;
    endfunction

    // Valid BCD orders like binary, so the magnitude check is a plain compare.
    assign load   = LOAD;
    assign load_q = (bcd_ok(LOAD_VAL) && LOAD_VAL <= LIM) ? LOAD_VAL : LIM;
`else
    assign load   = 1'b0;
    assign load_q = '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q  <= '0;
            CA <= 1'b0;
        end else if (CLR) begin
            Q  <= '0;
            CA <= 1'b0;
        end else if (load) begin
            Q  <= load_q;
            CA <= 1'b0;
        end else if (step) begin
            Q  <= stepped;
            CA <= ca_n;
        end else begin
            CA <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_limit_counter.sv
// tb_bcd_limit_counter: directed checks on three counter configurations (default, wrap, 3-digit wrap).
// LOAD checks are included when BCD_CNT_LOAD_EN is defined.
module tb_bcd_limit_counter;
    logic        CLK = 1'b0;
    logic        RESET, CLR, HOLD;
    logic        en0, en1, en2, dn0, dn1, dn2;
    logic [7:0]  q0, q1;
    logic [11:0] q2;
    logic        at0, at1, at2, ca0, ca1, ca2;
`ifdef BCD_CNT_LOAD_EN
    logic        ld0, ld1, ld2;
    logic [7:0]  lv0, lv1;
    logic [11:0] lv2;
`endif
    int npass = 0;
    int ntotal = 0;
    int e, pe;

    always #5 CLK = ~CLK;

    bcd_limit_counter u0 (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .en(en0), .HOLD(HOLD), .DOWN(dn0),
`ifdef BCD_CNT_LOAD_EN
        .LOAD(ld0), .LOAD_VAL(lv0),
`endif
        .Q(q0), .AT_LIMIT(at0), .CA(ca0));

    bcd_limit_counter #(.DIGITS(2), .LIMIT(30), .WRAP(1'b1)) u1 (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .en(en1), .HOLD(HOLD), .DOWN(dn1),
`ifdef BCD_CNT_LOAD_EN
        .LOAD(ld1), .LOAD_VAL(lv1),
`endif
        .Q(q1), .AT_LIMIT(at1), .CA(ca1));

    bcd_limit_counter #(.DIGITS(3), .LIMIT(250), .WRAP(1'b1)) u2 (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .en(en2), .HOLD(HOLD), .DOWN(dn2),
`ifdef BCD_CNT_LOAD_EN
        .LOAD(ld2), .LOAD_VAL(lv2),
`endif
        .Q(q2), .AT_LIMIT(at2), .CA(ca2));

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial begin
        RESET = 1'b1; CLR = 1'b0; HOLD = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        dn0 = 1'b0; dn1 = 1'b0; dn2 = 1'b0;
`ifdef BCD_CNT_LOAD_EN
        ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
        lv0 = '0; lv1 = '0; lv2 = '0;
`endif
        #12;
        chk("rst_q", q0, 0);
        chk("rst_ca", ca0, 0);
        chk("rst_at_up", at0, 0);
        dn0 = 1'b1;
        #1 chk("rst_at_down", at0, 1);
        dn0 = 1'b0;
        tick;
        RESET = 1'b0;
        en0 = 1'b1;
        e = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            pe = e;
            e = (e < 30) ? e + 1 : 30;
            chk("up_q", q0, bcd(e));
            chk("up_ca", ca0, 12'(e == 30 && pe != 30));
        end
        chk("sat_at", at0, 1);
        en0 = 1'b0;
        dn0 = 1'b1;
        #1 chk("toggle_at", at0, 0);
        tick;
        chk("toggle_ca", ca0, 0);
        chk("toggle_q", q0, 12'h30);
        dn0 = 1'b0;
        CLR = 1'b1;
        tick;
        chk("clr_q", q0, 0);
        chk("clr_ca", ca0, 0);
        CLR = 1'b0;
        en0 = 1'b1;
        repeat (15) tick;
        chk("cnt15", q0, 12'h15);
        HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_q", q0, 12'h15);
        end
        CLR = 1'b1;
        tick;
        chk("clr_hold_q", q0, 0);
        chk("clr_hold_ca", ca0, 0);
        CLR = 1'b0;
        HOLD = 1'b0;
        repeat (3) tick;
        chk("cnt3", q0, 12'h03);
        dn0 = 1'b1;
        CLR = 1'b1;
        tick;
        chk("clr_dn_q", q0, 0);
        chk("clr_dn_ca", ca0, 0);
        chk("clr_dn_at", at0, 1);
        CLR = 1'b0;
        dn0 = 1'b0;
        repeat (22) tick;
        chk("cnt22", q0, 12'h22);
        #3 RESET = 1'b1;
        #1 chk("async_rst_q", q0, 0);
        tick;
        chk("rst_hold_q", q0, 0);
        RESET = 1'b0;
        tick;
        chk("first_step", q0, 12'h01);
        dn0 = 1'b1;
        tick;
        chk("dn_q", q0, 0);
        chk("dn_ca", ca0, 1);
        chk("dn_at", at0, 1);
        tick;
        chk("dn_sat_q", q0, 0);
        chk("dn_sat_ca", ca0, 0);
        en0 = 1'b0;
        dn0 = 1'b0;
`ifdef BCD_CNT_LOAD_EN
        ld0 = 1'b1;
        lv0 = 8'h27;
        tick;
        chk("ld27", q0, 12'h27);
        chk("ld27_ca", ca0, 0);
        lv0 = 8'h3A;
        tick;
        chk("ld3A", q0, 12'h30);
        lv0 = 8'h45;
        tick;
        chk("ld45", q0, 12'h30);
        lv0 = 8'h29;
        en0 = 1'b1;
        tick;
        chk("ld_en_q", q0, 12'h29);
        lv0 = 8'h30;
        tick;
        chk("ld_lim_q", q0, 12'h30);
        chk("ld_lim_ca", ca0, 0);
        ld0 = 1'b0;
        en0 = 1'b0;
`endif
        en1 = 1'b1;
        e = 0;
        for (int i = 0; i < 62; i++) begin
            tick;
            e = (e == 30) ? 0 : e + 1;
            chk("wrap_up_q", q1, bcd(e));
            chk("wrap_up_ca", ca1, 12'(e == 30));
        end
        dn1 = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick;
            e = (e == 0) ? 30 : e - 1;
            chk("wrap_dn_q", q1, bcd(e));
            chk("wrap_dn_ca", ca1, 12'(e == 0));
        end
        en1 = 1'b0;
        dn2 = 1'b1;
        en2 = 1'b1;
        e = 0;
        for (int i = 0; i < 251; i++) begin
            tick;
            e = (e == 0) ? 250 : e - 1;
            chk("d3_q", q2, bcd(e));
            chk("d3_ca", ca2, 12'(e == 0));
        end
        en2 = 1'b0;
        chk("d3_at", at2, 1);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
